// File: rtl/ir_pkg.sv
// NEC IR receiver shared types: FSM states, pulse-width windows in microseconds,
// and a window-compare helper.
package ir_pkg;

  localparam int COUNT_W = 14;

  typedef logic [COUNT_W-1:0] us_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_REP_MARK
  } ir_state_e;

  localparam us_t TIMEOUT_US    = 14'd12000;
  localparam us_t LEAD_MARK_MIN = 14'd8000;
  localparam us_t LEAD_MARK_MAX = 14'd10000;
  localparam us_t DATA_SPC_MIN  = 14'd4000;
  localparam us_t DATA_SPC_MAX  = 14'd5000;
  localparam us_t REP_SPC_MIN   = 14'd2000;
  localparam us_t REP_SPC_MAX   = 14'd2500;
  localparam us_t BIT_MARK_MIN  = 14'd400;
  localparam us_t BIT_MARK_MAX  = 14'd750;
  localparam us_t ZERO_SPC_MIN  = 14'd400;
  localparam us_t ZERO_SPC_MAX  = 14'd750;
  localparam us_t ONE_SPC_MIN   = 14'd1400;
  localparam us_t ONE_SPC_MAX   = 14'd1900;

  function automatic logic in_win(
    input us_t w,
    input us_t lo,
    input us_t hi
  );
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Free-running microsecond prescaler feeding a saturating interval counter
// that restarts from zero on every line edge.
import ir_pkg::*;

module ir_pulse_timer #(
  parameter int CLKS_PER_TICK = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  output us_t  count_o
);

  localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_TICK - 1);

  logic [PW-1:0] pre_q, pre_d;
  us_t           cnt_q, cnt_d;
  logic          tick;

  assign tick = (pre_q == PMAX);

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (tick && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame receiver: synchronizes the demodulated line, times marks and
// spaces, and emits address/command with valid, repeat and error strobes.
import ir_pkg::*;

module nec_ir_receiver #(
  parameter int CLKS_PER_TICK = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ir_in,
  output logic [7:0] address,
  output logic [7:0] command,
  output logic       valid,
  output logic       repeat_evt,
  output logic       error
);

  logic       sync1_q, sync2_q, sync3_q;
  logic       fall, rise;
  us_t        width;

  ir_state_e  state_q, state_d;
  logic [4:0] bit_q, bit_d;
  logic [31:0] shift_q, shift_d;
  logic       have_q, have_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] cmd_q, cmd_d;
  logic       valid_q, valid_d;
  logic       rep_q, rep_d;
  logic       err_q, err_d;

  logic timeout, lead_ok, dspc_ok, rspc_ok;
  logic mark_ok, zero_ok, one_ok, chk_ok;

  assign fall = sync3_q & ~sync2_q;
  assign rise = ~sync3_q & sync2_q;

  ir_pulse_timer #(
    .CLKS_PER_TICK (CLKS_PER_TICK)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (fall | rise),
    .count_o (width)
  );

  assign timeout = (state_q != S_IDLE) && (width >= TIMEOUT_US);
  assign lead_ok = in_win(width, LEAD_MARK_MIN, LEAD_MARK_MAX);
  assign dspc_ok = in_win(width, DATA_SPC_MIN, DATA_SPC_MAX);
  assign rspc_ok = in_win(width, REP_SPC_MIN, REP_SPC_MAX);
  assign mark_ok = in_win(width, BIT_MARK_MIN, BIT_MARK_MAX);
  assign zero_ok = in_win(width, ZERO_SPC_MIN, ZERO_SPC_MAX);
  assign one_ok  = in_win(width, ONE_SPC_MIN, ONE_SPC_MAX);
  // Byte1 (inverted address) is left unchecked so extended NEC passes.
  assign chk_ok  = (shift_q[23:16] ^ shift_q[31:24]) == 8'hFF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
      state_q <= S_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      have_q  <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= ir_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      have_q  <= have_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    have_d  = have_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (fall) state_d = S_LEAD_MARK;
        S_LEAD_MARK:
          if (rise) state_d = lead_ok ? S_LEAD_SPACE : S_IDLE;
        S_LEAD_SPACE:
          if (fall) begin
            if (dspc_ok) begin
              state_d = S_BIT_MARK;
              bit_d   = '0;
            end else if (rspc_ok) begin
              state_d = S_REP_MARK;
            end else begin
              state_d = S_IDLE;
            end
          end
        S_BIT_MARK:
          if (rise) state_d = mark_ok ? S_BIT_SPACE : S_IDLE;
        S_BIT_SPACE:
          if (fall) begin
            if (zero_ok || one_ok) begin
              shift_d = {one_ok, shift_q[31:1]};
              bit_d   = bit_q + 5'd1;
              state_d = (bit_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            end else begin
              state_d = S_IDLE;
            end
          end
        S_STOP_MARK:
          if (rise) begin
            state_d = S_IDLE;
            if (mark_ok && chk_ok) have_d = 1'b1;
          end
        S_REP_MARK:
          if (rise) state_d = S_IDLE;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d = 1'b0;
    rep_d   = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    if (timeout) begin
      err_d = 1'b1;
    end else begin
      unique case (state_q)
        S_LEAD_MARK:
          err_d = rise & ~lead_ok;
        S_LEAD_SPACE:
          err_d = fall & ~(dspc_ok | rspc_ok);
        S_BIT_MARK:
          err_d = rise & ~mark_ok;
        S_BIT_SPACE:
          err_d = fall & ~(zero_ok | one_ok);
        S_STOP_MARK:
          if (rise) begin
            if (mark_ok && chk_ok) begin
              valid_d = 1'b1;
              addr_d  = shift_q[7:0];
              cmd_d   = shift_q[23:16];
            end else begin
              err_d = 1'b1;
            end
          end
        S_REP_MARK: begin
          rep_d = rise & mark_ok & have_q;
          err_d = rise & ~mark_ok;
        end
        default: ;
      endcase
    end
  end

  assign address    = addr_q;
  assign command    = cmd_q;
  assign valid      = valid_q;
  assign repeat_evt = rep_q;
  assign error      = err_q;

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Directed NEC waveforms with a scoreboard of expected strobes, checked by
// immediate assertions as the receiver reports them.
module tb_nec_ir_receiver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ir_in = 1'b1;
  logic [7:0] address, command;
  logic       valid, repeat_evt, error;

  int checks = 0;
  int errors = 0;
  int unsigned pcnt = 0;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] addr;
    logic [7:0] cmd;
  } exp_t;

  exp_t q[$];
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_cmd  = 8'h00;

  nec_ir_receiver #(
    .CLKS_PER_TICK (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ir_in      (ir_in),
    .address    (address),
    .command    (command),
    .valid      (valid),
    .repeat_evt (repeat_evt),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Mirrors the prescaler phase so waveform edges never coincide with a tick.
  always @(posedge clk) pcnt <= reset_n ? pcnt + 1 : 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_valid(input logic [7:0] a, input logic [7:0] c);
    m_addr = a;
    m_cmd  = c;
    q.push_back('{3'b100, a, c});
  endtask

  task automatic push_rep();
    q.push_back('{3'b010, m_addr, m_cmd});
  endtask

  task automatic push_err();
    q.push_back('{3'b001, m_addr, m_cmd});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid | repeat_evt | error) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 32'({valid, repeat_evt, error}), 32'd0);
      end else begin
        e = q.pop_front();
        check("kind", 32'({valid, repeat_evt, error}), 32'(e.kind));
        check("address", 32'(address), 32'(e.addr));
        check("command", 32'(command), 32'(e.cmd));
      end
    end
  end

  task automatic wait_us(input int t);
    repeat (4 * t) @(negedge clk);
  endtask

  task automatic align();
    @(negedge clk);
    while (pcnt % 4 != 0) @(negedge clk);
  endtask

  task automatic mark(input int t);
    ir_in = 1'b0;
    wait_us(t);
    ir_in = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbits,
                            input int zlo, input int zhi,
                            input int olo, input int ohi, input bit term);
    align();
    mark(9000);
    wait_us(4500);
    for (int i = 0; i < nbits; i++) begin
      mark(560);
      if (w[i]) wait_us((i % 2 == 1) ? ohi : olo);
      else      wait_us((i % 2 == 1) ? zhi : zlo);
    end
    if (term) begin
      mark(560);
      wait_us(2000);
    end
  endtask

  task automatic send_nec(input logic [31:0] w);
    send_frame(w, 32, 560, 560, 1690, 1690, 1'b1);
  endtask

  task automatic send_repeat();
    align();
    mark(9000);
    wait_us(2250);
    mark(560);
    wait_us(2000);
  endtask

  function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] ai,
                                      input logic [7:0] c, input logic [7:0] ci);
    return {ci, c, ai, a};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("rst_address", 32'(address), 32'h00);
    check("rst_command", 32'(command), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_repeat", 32'(repeat_evt), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset_n = 1'b1;
    wait_us(100);

    send_repeat();
    check("rep_no_frame_drain", 32'(q.size()), 32'd0);

    push_valid(8'h00, 8'h6D);
    send_nec(nec(8'h00, 8'hFF, 8'h6D, 8'h92));
    check("frame1_drain", 32'(q.size()), 32'd0);

    push_rep();
    send_repeat();
    check("repeat_drain", 32'(q.size()), 32'd0);
    check("repeat_cmd_held", 32'(command), 32'h6D);

    push_err();
    send_nec(nec(8'h00, 8'hFF, 8'h6D, 8'h93));
    check("chk_drain", 32'(q.size()), 32'd0);
    check("chk_cmd_held", 32'(command), 32'h6D);

    push_err();
    align();
    mark(7000);
    wait_us(2000);
    check("short_lead_drain", 32'(q.size()), 32'd0);

    push_err();
    align();
    ir_in = 1'b0;
    wait_us(12100);
    check("timeout_seen", 32'(q.size()), 32'd0);
    wait_us(900);
    ir_in = 1'b1;
    wait_us(2000);

    send_frame(nec(8'h5A, 8'hA5, 8'hFD, 8'h02), 15,
               560, 560, 1690, 1690, 1'b0);
    ir_in = 1'b0;
    wait_us(200);
    #1;
    reset_n = 1'b0;
    ir_in = 1'b1;
    m_addr = 8'h00;
    m_cmd = 8'h00;
    #1;
    check("midrst_address", 32'(address), 32'h00);
    check("midrst_command", 32'(command), 32'h00);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    wait_us(500);
    push_valid(8'h5A, 8'hFD);
    send_nec(nec(8'h5A, 8'hA5, 8'hFD, 8'h02));
    check("post_rst_drain", 32'(q.size()), 32'd0);

    push_valid(8'h3C, 8'h96);
    send_frame(nec(8'h3C, 8'hC3, 8'h96, 8'h69), 32,
               400, 750, 1400, 1900, 1'b1);
    check("win_edge_drain", 32'(q.size()), 32'd0);

    push_err();
    send_frame(32'h0000_0000, 1, 399, 399, 1690, 1690, 1'b1);
    check("space399_drain", 32'(q.size()), 32'd0);

    push_err();
    send_frame(32'h0000_0001, 1, 560, 560, 1901, 1901, 1'b1);
    check("space1901_drain", 32'(q.size()), 32'd0);

    check("final_address", 32'(address), 32'h3C);
    check("final_command", 32'(command), 32'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
